// File: rtl/spi_mc_pkg.sv
// Shared constants, register map and FSM states
// for the multi-channel SPI master.
package spi_mc_pkg;

    localparam int REG_RST    = 0;
    localparam int REG_START  = 1;
    localparam int REG_SIZE   = 2;
    localparam int REG_CONF   = 4;
    localparam int REG_CS     = 5;
    localparam int REG_DIV    = 6;
    localparam int MEM_OFFSET = 16;

    localparam logic [7:0] VERSION = 8'h01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_LOAD
    } state_t;

    // Bit position inside a byte for transfer bit k
    function automatic logic [2:0] bit_pos(
        input logic [2:0] k,
        input logic       lsb
    );
        return lsb ? k : 3'd7 - k;
    endfunction

endpackage

// File: rtl/spi_sbus_mc_if.sv
// Simple-bus register/memory port of the SPI master.
// The bus master drives address, data and strobes.
interface spi_sbus_mc_if #(
    parameter int ABUSWIDTH = 16
);

    logic [ABUSWIDTH-1:0] BUS_ADD;
    logic [7:0]           BUS_DATA_IN;
    logic [7:0]           BUS_DATA_OUT;
    logic                 BUS_RD;
    logic                 BUS_WR;

    modport master (
        output BUS_ADD,
        output BUS_DATA_IN,
        output BUS_RD,
        output BUS_WR,
        input  BUS_DATA_OUT
    );

    modport slave (
        input  BUS_ADD,
        input  BUS_DATA_IN,
        input  BUS_RD,
        input  BUS_WR,
        output BUS_DATA_OUT
    );

endinterface

// File: rtl/spi_mc_clkgen.sv
// Half-period tick generator: one tick every
// i_div+1 enabled cycles, restarted by i_clr.
module spi_mc_clkgen
    import spi_mc_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;

    assign o_tick = i_en && (r_cnt == i_div);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_sbus_mc.sv
// Multi-channel SPI master: register file, FSM,
// shift/sample datapath and TX/RX byte memories.
module spi_sbus_mc
    import spi_mc_pkg::*;
#(
    parameter int ABUSWIDTH = 16,
    parameter int MEM_BYTES = 4,
    parameter int N_CS      = 4,
    parameter int DIV_W     = 16
) (
    input  logic            BUS_CLK,
    input  logic            BUS_RST_N,
    spi_sbus_mc_if.slave    bus,
    output logic            SCLK,
    output logic            SDI,
    input  logic            SDO,
    input  logic            EXT_START,
    output logic [N_CS-1:0] SEN,
    output logic            SLD
);

    localparam int NB = MEM_BYTES * 8;
    localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

    typedef logic [ABUSWIDTH-1:0] addr_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [15:0]      r_size;
    logic [3:0]       r_conf;
    logic [7:0]       r_cs;
    logic [DIV_W-1:0] r_div;
    logic             r_done;
    logic             r_act;
    logic             r_sdi;
    logic [16:0]      r_hcnt;
    logic [7:0]       r_rdata;
    logic [7:0]       r_tx [MEM_BYTES];
    logic [7:0]       r_rx [MEM_BYTES];

    logic        w_cpha;
    logic        w_cpol;
    logic        w_lsb;
    logic        w_idle;
    logic        w_tick;
    logic        w_wr_rst;
    logic        w_req;
    logic        w_accept;
    logic        w_cfg_we;
    logic        w_in_tx;
    logic        w_in_rx;
    logic [AW-1:0] w_tidx;
    logic [AW-1:0] w_ridx;
    logic [15:0] w_len;
    logic [16:0] w_last;
    logic [15:0] w_tk;
    logic [15:0] w_tk1;
    logic [15:0] w_lk;
    logic        w_lead;
    logic        w_trail;
    logic        w_drv;
    logic [15:0] w_dk;
    logic        w_smp;
    logic [15:0] w_sk;
    logic        w_tx_bit;
    logic        w_sen_on;
    logic [7:0]  w_rd;

    assign w_cpha = r_conf[0];
    assign w_cpol = r_conf[1];
    assign w_lsb  = r_conf[2];
    assign w_idle = (r_state == ST_IDLE);

    assign w_wr_rst = bus.BUS_WR && (bus.BUS_ADD == addr_t'(REG_RST));
    assign w_req    = (bus.BUS_WR && (bus.BUS_ADD == addr_t'(REG_START)))
                   || (EXT_START && r_conf[3]);
    assign w_accept = w_idle && w_req && (r_size != 16'd0) && !w_wr_rst;
    assign w_cfg_we = bus.BUS_WR && w_idle;

    assign w_in_tx = (bus.BUS_ADD >= addr_t'(MEM_OFFSET))
                  && (bus.BUS_ADD <  addr_t'(MEM_OFFSET + MEM_BYTES));
    assign w_in_rx = (bus.BUS_ADD >= addr_t'(MEM_OFFSET + MEM_BYTES))
                  && (bus.BUS_ADD <  addr_t'(MEM_OFFSET + 2 * MEM_BYTES));
    assign w_tidx  = AW'(bus.BUS_ADD - addr_t'(MEM_OFFSET));
    assign w_ridx  = AW'(bus.BUS_ADD - addr_t'(MEM_OFFSET + MEM_BYTES));

    assign w_len  = (r_size > 16'(NB)) ? 16'(NB) : r_size;
    assign w_last = {w_len, 1'b0} - 17'd1;
    assign w_tk   = r_hcnt[16:1];
    assign w_tk1  = w_tk + 16'd1;

    spi_mc_clkgen #(
        .DIV_W (DIV_W)
    ) u_clkgen (
        .i_clk   (BUS_CLK),
        .i_rst_n (BUS_RST_N),
        .i_en    (!w_idle),
        .i_clr   (w_accept),
        .i_div   (r_div),
        .o_tick  (w_tick)
    );

    always_ff @(posedge BUS_CLK) begin
        if (!BUS_RST_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Each SHIFT tick is a trailing edge (even count) or a leading edge (odd)
    always_comb begin
        w_state_nx = r_state;
        w_lead     = 1'b0;
        w_trail    = 1'b0;
        w_lk       = '0;
        w_drv      = 1'b0;
        w_dk       = '0;
        w_smp      = 1'b0;
        w_sk       = '0;
        if (w_wr_rst) begin
            w_state_nx = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) w_state_nx = ST_SETUP;
                end
                ST_SETUP: begin
                    if (w_tick) begin
                        w_state_nx = ST_SHIFT;
                        w_lead     = 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (w_tick) begin
                        if (r_hcnt == w_last) begin
                            w_state_nx = ST_HOLD;
                        end else if (!r_hcnt[0]) begin
                            w_trail = 1'b1;
                        end else begin
                            w_lead = 1'b1;
                            w_lk   = w_tk1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_tick) w_state_nx = ST_LOAD;
                end
                ST_LOAD: begin
                    if (w_tick) w_state_nx = ST_IDLE;
                end
                default: w_state_nx = ST_IDLE;
            endcase
        end
        if (w_accept && !w_cpha) begin
            w_drv = 1'b1;
        end
        if (w_lead) begin
            if (w_cpha) begin
                w_drv = 1'b1;
                w_dk  = w_lk;
            end else begin
                w_smp = 1'b1;
                w_sk  = w_lk;
            end
        end
        if (w_trail) begin
            if (w_cpha) begin
                w_smp = 1'b1;
                w_sk  = w_tk;
            end else if (w_tk1 < w_len) begin
                w_drv = 1'b1;
                w_dk  = w_tk1;
            end
        end
    end

    assign w_tx_bit = r_tx[AW'(w_dk >> 3)][bit_pos(w_dk[2:0], w_lsb)];

    always_comb begin
        w_rd = '0;
        if (w_in_tx) begin
            w_rd = r_tx[w_tidx];
        end else if (w_in_rx) begin
            w_rd = r_rx[w_ridx];
        end else begin
            case (bus.BUS_ADD)
                addr_t'(REG_RST):      w_rd = VERSION;
                addr_t'(REG_START):    w_rd = {7'd0, r_done};
                addr_t'(REG_SIZE):     w_rd = r_size[7:0];
                addr_t'(REG_SIZE + 1): w_rd = r_size[15:8];
                addr_t'(REG_CONF):     w_rd = {4'd0, r_conf};
                addr_t'(REG_CS):       w_rd = r_cs;
                addr_t'(REG_DIV):      w_rd = r_div[7:0];
                addr_t'(REG_DIV + 1):  w_rd = 8'(r_div[DIV_W-1:8]);
                default:               w_rd = '0;
            endcase
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (!BUS_RST_N) begin
            r_size  <= '0;
            r_conf  <= '0;
            r_cs    <= '0;
            r_div   <= '0;
            r_done  <= 1'b1;
            r_act   <= 1'b0;
            r_sdi   <= 1'b0;
            r_hcnt  <= '0;
            r_rdata <= '0;
        end else begin
            if (w_cfg_we) begin
                case (bus.BUS_ADD)
                    addr_t'(REG_SIZE):     r_size[7:0]  <= bus.BUS_DATA_IN;
                    addr_t'(REG_SIZE + 1): r_size[15:8] <= bus.BUS_DATA_IN;
                    addr_t'(REG_CONF):     r_conf       <= bus.BUS_DATA_IN[3:0];
                    addr_t'(REG_CS):       r_cs         <= bus.BUS_DATA_IN;
                    addr_t'(REG_DIV):      r_div[7:0]   <= bus.BUS_DATA_IN;
                    addr_t'(REG_DIV + 1):
                        r_div[DIV_W-1:8] <= bus.BUS_DATA_IN[DIV_W-9:0];
                    default: ;
                endcase
            end
            if (w_wr_rst) begin
                r_done  <= 1'b1;
                r_act   <= 1'b0;
                r_sdi   <= 1'b0;
                r_rdata <= '0;
            end else begin
                if (w_accept) begin
                    r_done <= 1'b0;
                    r_hcnt <= '0;
                    r_act  <= 1'b0;
                end
                if (r_state == ST_SHIFT && w_tick) r_hcnt <= r_hcnt + 17'd1;
                if (w_lead)  r_act <= 1'b1;
                if (w_trail) r_act <= 1'b0;
                if (w_drv)   r_sdi <= w_tx_bit;
                if (r_state == ST_HOLD && w_tick) r_sdi  <= 1'b0;
                if (r_state == ST_LOAD && w_tick) r_done <= 1'b1;
                if (bus.BUS_RD) r_rdata <= w_rd;
            end
        end
    end

    // Memories are deliberately left uninitialised by either reset
    always_ff @(posedge BUS_CLK) begin
        if (w_cfg_we && w_in_tx) begin
            r_tx[w_tidx] <= bus.BUS_DATA_IN;
        end
        if (w_smp) begin
            r_rx[AW'(w_sk >> 3)][bit_pos(w_sk[2:0], w_lsb)] <= SDO;
        end
    end

    assign w_sen_on = (r_state == ST_SETUP)
                   || (r_state == ST_SHIFT)
                   || (r_state == ST_HOLD);

    always_comb begin
        SEN = '0;
        for (int i = 0; i < N_CS; i++) begin
            SEN[i] = w_sen_on && (r_cs == 8'(i));
        end
    end

    assign SCLK             = r_act ^ w_cpol;
    assign SDI              = r_sdi;
    assign SLD              = (r_state == ST_LOAD);
    assign bus.BUS_DATA_OUT = r_rdata;

endmodule

// File: tb/tb_spi_sbus_mc.sv
// Randomised bench for spi_sbus_mc with an
// edge-level monitor and a bit-stream reference model.
module tb_spi_sbus_mc;

    localparam int MB  = 4;
    localparam int NCS = 4;
    localparam int AB  = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           sclk;
    logic           sdi;
    logic           sdo;
    logic           ext = 1'b0;
    logic [NCS-1:0] sen;
    logic           sld;
    bit             inv = 1'b0;

    always #5 clk = ~clk;

    spi_sbus_mc_if #(.ABUSWIDTH(AB)) bus ();

    assign sdo = sdi ^ inv;

    spi_sbus_mc #(
        .ABUSWIDTH (AB),
        .MEM_BYTES (MB),
        .N_CS      (NCS),
        .DIV_W     (16)
    ) dut (
        .BUS_CLK   (clk),
        .BUS_RST_N (rst_n),
        .bus       (bus),
        .SCLK      (sclk),
        .SDI       (sdi),
        .SDO       (sdo),
        .EXT_START (ext),
        .SEN       (sen),
        .SLD       (sld)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic bw(input int a, input logic [7:0] d);
        @(posedge clk);
        #1;
        bus.BUS_ADD     = AB'(a);
        bus.BUS_DATA_IN = d;
        bus.BUS_WR      = 1'b1;
        @(posedge clk);
        #1;
        bus.BUS_WR = 1'b0;
    endtask

    task automatic br(input int a, output logic [7:0] d);
        @(posedge clk);
        #1;
        bus.BUS_ADD = AB'(a);
        bus.BUS_RD  = 1'b1;
        @(posedge clk);
        #1;
        bus.BUS_RD = 1'b0;
        d = bus.BUS_DATA_OUT;
    endtask

    // Monitor: counts SCLK periods, captures SDI at the sampling edge
    bit             mclr = 1'b1;
    bit             mcpol;
    bit             mcpha;
    int             n_lead, n_sld, sld_len, pmin, pmax, last_lc, cyc;
    bit             q[$];
    logic [NCS-1:0] sen_or;
    logic           pv, sld_pv;

    always @(negedge clk) begin
        cyc++;
        if (mclr) begin
            n_lead  = 0;
            n_sld   = 0;
            sld_len = 0;
            pmin    = 1000000;
            pmax    = 0;
            last_lc = -1;
            q.delete();
            sen_or  = '0;
            pv      = sclk;
            sld_pv  = sld;
        end else begin
            if (sclk !== pv) begin
                if (sclk !== mcpol) begin
                    n_lead++;
                    if (last_lc >= 0) begin
                        if (cyc - last_lc < pmin) pmin = cyc - last_lc;
                        if (cyc - last_lc > pmax) pmax = cyc - last_lc;
                    end
                    last_lc = cyc;
                    sen_or |= sen;
                    if (!mcpha) q.push_back(sdi);
                end else if (mcpha) begin
                    q.push_back(sdi);
                end
            end
            pv = sclk;
            if (sld) sld_len++;
            if (sld && !sld_pv) n_sld++;
            sld_pv = sld;
        end
    end

    logic [7:0] txm [MB];
    logic [7:0] rxm [MB];
    logic [7:0] rxk [MB];

    task automatic mon_reset();
        mclr = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        mclr = 1'b0;
    endtask

    task automatic setup(input logic [3:0] conf, input int cs,
                         input int div, input int size);
        bw(4, {4'd0, conf});
        bw(5, cs[7:0]);
        bw(6, div[7:0]);
        bw(7, div[15:8]);
        bw(2, size[7:0]);
        bw(3, size[15:8]);
        for (int i = 0; i < MB; i++) bw(16 + i, txm[i]);
        mcpol = conf[1];
        mcpha = conf[0];
    endtask

    task automatic xfer(input string nm, input logic [3:0] conf,
                        input int cs, input int div, input int size,
                        input bit use_ext, input bit poke);
        logic [7:0]     d;
        logic [NCS-1:0] es;
        int             n, t, errs;
        bit             eb;
        int             pos;
        setup(conf, cs, div, size);
        inv = 1'($urandom_range(0, 1));
        mon_reset();
        if (use_ext) begin
            @(posedge clk);
            #1;
            ext = 1'b1;
            @(posedge clk);
            #1;
            ext = 1'b0;
        end else begin
            bw(1, 8'h00);
        end
        br(1, d);
        chk({nm, "_busy"}, 32'(d), 32'd0);
        if (poke) begin
            for (int i = 0; i < 5000 && n_lead < 3; i++) @(posedge clk);
            bw(4, {4'd0, conf ^ 4'h7});
            bw(16, ~txm[0]);
            bw(1, 8'h00);
        end
        t = 0;
        while (!(n_sld >= 1 && !sld) && t < 20000) begin
            @(posedge clk);
            t++;
        end
        chk({nm, "_timeout"}, 32'(t < 20000), 32'd1);
        n    = (size > MB * 8) ? MB * 8 : size;
        errs = 0;
        for (int k = 0; k < n; k++) begin
            pos = conf[2] ? (k % 8) : 7 - (k % 8);
            eb  = txm[k / 8][pos];
            if (k >= q.size() || q[k] !== eb) errs++;
            rxm[k / 8][pos] = eb ^ inv;
            rxk[k / 8][pos] = 1'b1;
        end
        es = (cs < NCS) ? NCS'(1 << cs) : '0;
        chk({nm, "_periods"}, 32'(n_lead), 32'(n));
        chk({nm, "_sdi_bits"}, 32'(q.size()), 32'(n));
        chk({nm, "_sdi_errs"}, 32'(errs), 32'd0);
        chk({nm, "_sen"}, 32'(sen_or), 32'(es));
        if (n > 1) begin
            chk({nm, "_pmin"}, 32'(pmin), 32'(2 * (div + 1)));
            chk({nm, "_pmax"}, 32'(pmax), 32'(2 * (div + 1)));
        end
        chk({nm, "_sld_cnt"}, 32'(n_sld), 32'd1);
        chk({nm, "_sld_len"}, 32'(sld_len), 32'(div + 1));
        br(1, d);
        chk({nm, "_done"}, 32'(d), 32'd1);
        chk({nm, "_sclk_idle"}, 32'(sclk), 32'(conf[1]));
        chk({nm, "_sen_idle"}, 32'(sen), 32'd0);
        for (int i = 0; i < MB; i++) begin
            br(16 + MB + i, d);
            chk({nm, "_rx"}, 32'(d & rxk[i]), 32'(rxm[i] & rxk[i]));
        end
    endtask

    logic [7:0] rd;
    logic [3:0] cf;

    initial begin
        bus.BUS_ADD     = '0;
        bus.BUS_DATA_IN = '0;
        bus.BUS_RD      = 1'b0;
        bus.BUS_WR      = 1'b0;
        for (int i = 0; i < MB; i++) begin
            txm[i] = '0;
            rxm[i] = '0;
            rxk[i] = '0;
        end
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;

        br(0, rd);
        chk("rst_version", 32'(rd), 32'h01);
        br(1, rd);
        chk("rst_done", 32'(rd), 32'h01);
        br(4, rd);
        chk("rst_conf", 32'(rd), 32'h00);
        br(30, rd);
        chk("rst_unmapped", 32'(rd), 32'h00);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_sen", 32'(sen), 32'd0);
        chk("rst_sld", 32'(sld), 32'd0);

        txm[0] = 8'hA5;
        txm[1] = 8'h3C;
        xfer("mode0", 4'b0000, 2, 1, 16, 1'b0, 1'b0);

        for (int m = 1; m < 4; m++) begin
            txm[0] = 8'h01;
            cf = {2'b01, 2'(m)};
            xfer("lsb_mode", cf, m, 0, 8, 1'b0, 1'b0);
        end

        for (int i = 0; i < MB; i++) txm[i] = 8'($urandom);
        xfer("size40", 4'b0000, 0, 0, 40, 1'b0, 1'b0);

        bw(2, 8'd0);
        bw(3, 8'd0);
        mon_reset();
        bw(1, 8'h00);
        repeat (20) @(posedge clk);
        chk("size0_sclk", 32'(n_lead), 32'd0);
        br(1, rd);
        chk("size0_done", 32'(rd), 32'd1);

        setup(4'b0000, 1, 0, 8);
        mon_reset();
        @(posedge clk);
        #1;
        ext = 1'b1;
        @(posedge clk);
        #1;
        ext = 1'b0;
        repeat (20) @(posedge clk);
        chk("ext_off_sclk", 32'(n_lead), 32'd0);
        br(1, rd);
        chk("ext_off_done", 32'(rd), 32'd1);

        for (int i = 0; i < MB; i++) txm[i] = 8'($urandom);
        xfer("poke", 4'b0011, 1, 1, 16, 1'b0, 1'b1);

        setup(4'b0010, 3, 1, 16);
        mon_reset();
        bw(1, 8'h00);
        for (int i = 0; i < 5000 && n_lead < 6; i++) @(posedge clk);
        bw(0, 8'h00);
        chk("srst_sen", 32'(sen), 32'd0);
        chk("srst_sclk", 32'(sclk), 32'd1);
        chk("srst_sld", 32'(sld), 32'd0);
        repeat (20) @(posedge clk);
        chk("srst_no_sld", 32'(n_sld), 32'd0);
        br(1, rd);
        chk("srst_done", 32'(rd), 32'd1);
        rxk[0] = '0;
        rxk[1] = '0;
        xfer("after_srst", 4'b0010, 3, 1, 16, 1'b0, 1'b0);

        for (int it = 0; it < 8; it++) begin
            bit ue;
            ue = 1'($urandom_range(0, 1));
            cf = {ue, 3'($urandom_range(0, 7))};
            for (int i = 0; i < MB; i++) txm[i] = 8'($urandom);
            xfer("rand", cf, $urandom_range(0, 5), $urandom_range(0, 3),
                 $urandom_range(1, 40), ue, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
